rc4_prga_gen: RTL and testbench

Parametrised RC4 keystream generator and decryptor. Operates on an S-box that an upstream KSA block has already initialised. Reads a length-prefixed ciphertext, then writes the length prefix and the XOR-decrypted bytes to plaintext memory. Supersedes the fixed 8-bit PRGA:
- multi-byte length prefix
- RC4-drop[N] keystream discard
- i and j restart on every run
- zero-length messages supported

---
 rtl/rc4_pkg.sv | 20 ++
 rtl/rc4_prga_gen_if.sv | 21 ++
 rtl/rc4_prga_gen_ks_step.sv | 95 +++++++++
 rtl/rc4_prga_gen.sv | 155 +++++++++++++++
 tb/tb_rc4_prga_gen.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and constants for the RC4 keystream generator
package rc4_pkg;
   localparam int         S_SIZE   = 256;
   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   typedef logic [$clog2(S_SIZE)-1:0] sidx_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_RD_LEN, ST_WR_LEN, ST_DROP, ST_MSG, ST_WR_PT
   } prga_state_t;

   typedef enum logic [2:0] {
      KS_IDLE, KS_S1, KS_S2, KS_S3, KS_S4, KS_S5, KS_S6, KS_S7
   } ks_state_t;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= PRINT_LO) && (b <= PRINT_HI);
   endfunction
endpackage

// File: rtl/rc4_prga_gen_if.sv
// rtl/rc4_prga_gen_if.sv - S-box, ciphertext and plaintext memory ports of the generator
interface rc4_prga_gen_if #(parameter int MSG_AW = 8);
   logic [7:0]        s_addr;
   logic [7:0]        s_rddata;
   logic [7:0]        s_wrdata;
   logic              s_wren;
   logic [MSG_AW-1:0] ct_addr;
   logic [7:0]        ct_rddata;
   logic [MSG_AW-1:0] pt_addr;
   logic [7:0]        pt_wrdata;
   logic              pt_wren;

   modport master (
      output s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren,
      input  s_rddata, ct_rddata
   );
   modport slave (
      input  s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren,
      output s_rddata, ct_rddata
   );
endinterface

// File: rtl/rc4_prga_gen_ks_step.sv
// rtl/rc4_prga_gen_ks_step.sv - one RC4 swap-and-pad step (S0..S7); the start cycle itself is S0
module rc4_ks_step
   import rc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       start,
   output logic       idle,
   output logic       pad_rd,
   output logic       done,
   output logic [7:0] pad,
   output logic [7:0] s_addr,
   input  logic [7:0] s_rddata,
   output logic [7:0] s_wrdata,
   output logic       s_wren
);
   ks_state_t state, state_nxt;
   sidx_t     i, j, si, sj;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= KS_IDLE;
         i     <= '0;
         j     <= '0;
         si    <= '0;
         sj    <= '0;
         pad   <= '0;
      end else begin
         state <= state_nxt;
         if (clr) begin
            i <= '0;
            j <= '0;
         end else begin
            case (state)
               KS_IDLE: if (start) i <= i + 1'b1;
               KS_S1: begin
                  si <= s_rddata;
                  j  <= j + s_rddata;
               end
               KS_S3:   sj  <= s_rddata;
               KS_S7:   pad <= s_rddata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nxt = state;
      s_addr    = '0;
      s_wrdata  = '0;
      s_wren    = 1'b0;
      pad_rd    = 1'b0;
      done      = 1'b0;
      idle      = 1'b0;
      case (state)
         KS_IDLE: begin
            idle = 1'b1;
            if (start) begin
               s_addr    = i + 1'b1;
               state_nxt = KS_S1;
            end
         end
         KS_S1: state_nxt = KS_S2;
         KS_S2: begin
            s_addr    = j;
            state_nxt = KS_S3;
         end
         KS_S3: state_nxt = KS_S4;
         KS_S4: begin
            s_addr    = j;
            s_wrdata  = si;
            s_wren    = 1'b1;
            state_nxt = KS_S5;
         end
         KS_S5: begin
            s_addr    = i;
            s_wrdata  = sj;
            s_wren    = 1'b1;
            state_nxt = KS_S6;
         end
         KS_S6: begin
            s_addr    = si + sj;
            pad_rd    = 1'b1;
            state_nxt = KS_S7;
         end
         KS_S7: begin
            done      = 1'b1;
            state_nxt = KS_IDLE;
         end
         default: state_nxt = KS_IDLE;
      endcase
   end
endmodule

// File: rtl/rc4_prga_gen.sv
// rtl/rc4_prga_gen.sv - RC4-drop[N] keystream decryptor for length-prefixed messages; option PRGA_VALID_CHECK_EN
module rc4_prga_gen
   import rc4_pkg::*;
#(
   parameter int MSG_AW    = 8,
   parameter int LEN_BYTES = 1,
   parameter int DROP_N    = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   output logic           rdy,
   rc4_prga_gen_if.master mem,
   output logic           pt_valid
);
   localparam int LW = 8 * LEN_BYTES;
   localparam int CW = ((LW > MSG_AW) ? LW : MSG_AW) + 1;
   localparam int BW = $clog2(LEN_BYTES) + 1;
   localparam logic [CW-1:0] LEN_MAX   = CW'((2 ** MSG_AW) - 1 - LEN_BYTES);
   localparam logic [16:0]   DROP_LAST = 17'((DROP_N > 0) ? DROP_N - 1 : 0);

   prga_state_t       state, state_nxt;
   logic [LW-1:0]     len_q;
   logic [CW-1:0]     len_sat;
   logic [BW-1:0]     bi;
   logic              rd_ph;
   logic [MSG_AW-1:0] k, msg_addr;
   logic [16:0]       drop_cnt;
   logic [7:0]        c, pt_byte, ks_pad;
   logic              ks_clr, ks_start, ks_idle, ks_pad_rd, ks_done;
   logic              last_len_byte, last_msg_byte, abort;

   assign len_sat       = (CW'(len_q) > LEN_MAX) ? LEN_MAX : CW'(len_q);
   assign msg_addr      = MSG_AW'(LEN_BYTES) + k;
   assign pt_byte       = ks_pad ^ c;
   assign last_len_byte = (bi == BW'(LEN_BYTES - 1));
   assign last_msg_byte = ((CW'(k) + 1'b1) == len_sat);

   rc4_ks_step u_ks (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (ks_clr),
      .start    (ks_start),
      .idle     (ks_idle),
      .pad_rd   (ks_pad_rd),
      .done     (ks_done),
      .pad      (ks_pad),
      .s_addr   (mem.s_addr),
      .s_rddata (mem.s_rddata),
      .s_wrdata (mem.s_wrdata),
      .s_wren   (mem.s_wren)
   );

`ifdef PRGA_VALID_CHECK_EN
   assign abort = !is_printable(pt_byte);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         pt_valid <= 1'b1;
      else if (state == ST_IDLE && en)    pt_valid <= 1'b1;
      else if (state == ST_WR_PT && abort) pt_valid <= 1'b0;
   end
`else
   assign abort    = 1'b0;
   assign pt_valid = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q    <= '0;
         bi       <= '0;
         rd_ph    <= 1'b0;
         k        <= '0;
         drop_cnt <= '0;
         c        <= '0;
      end else begin
         case (state)
            ST_IDLE: if (en) begin
               len_q    <= '0;
               bi       <= '0;
               rd_ph    <= 1'b0;
               k        <= '0;
               drop_cnt <= '0;
            end
            ST_RD_LEN: begin
               rd_ph <= ~rd_ph;
               // Bytes shift in from the top so the first (least significant) lands at bit 0.
               if (rd_ph) begin
                  len_q <= (len_q >> 8) | (LW'(mem.ct_rddata) << (LW - 8));
                  bi    <= last_len_byte ? '0 : bi + 1'b1;
               end
            end
            ST_WR_LEN: bi <= bi + 1'b1;
            ST_DROP:   if (ks_done) drop_cnt <= drop_cnt + 1'b1;
            ST_MSG:    if (ks_done) c <= mem.ct_rddata;
            ST_WR_PT:  k <= k + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt     = state;
      rdy           = 1'b0;
      ks_clr        = 1'b0;
      ks_start      = 1'b0;
      mem.ct_addr   = '0;
      mem.pt_addr   = '0;
      mem.pt_wrdata = '0;
      mem.pt_wren   = 1'b0;
      case (state)
         ST_IDLE: begin
            rdy = 1'b1;
            if (en) begin
               ks_clr    = 1'b1;
               state_nxt = ST_RD_LEN;
            end
         end
         ST_RD_LEN: begin
            mem.ct_addr = MSG_AW'(bi);
            if (rd_ph && last_len_byte) state_nxt = ST_WR_LEN;
         end
         ST_WR_LEN: begin
            mem.pt_wren   = 1'b1;
            mem.pt_addr   = MSG_AW'(bi);
            mem.pt_wrdata = 8'(len_sat >> (8 * bi));
            if (last_len_byte) begin
               if (len_sat == '0)   state_nxt = ST_IDLE;
               else if (DROP_N > 0) state_nxt = ST_DROP;
               else                 state_nxt = ST_MSG;
            end
         end
         ST_DROP: begin
            ks_start = ks_idle;
            if (ks_done && drop_cnt == DROP_LAST) state_nxt = ST_MSG;
         end
         ST_MSG: begin
            ks_start = ks_idle;
            if (ks_pad_rd) mem.ct_addr = msg_addr;
            if (ks_done)   state_nxt = ST_WR_PT;
         end
         ST_WR_PT: begin
            mem.pt_wren   = 1'b1;
            mem.pt_addr   = msg_addr;
            mem.pt_wrdata = pt_byte;
            state_nxt     = (abort || last_msg_byte) ? ST_IDLE : ST_MSG;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_rc4_prga_gen.sv
// tb/tb_rc4_prga_gen.sv - scoreboard bench for rc4_prga_gen over three parameter sets
`timescale 1ns/1ps
module tb_rc4_prga_gen;
   localparam int AW = 10;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] en    = '0;
   logic [2:0] rdy;
   logic [2:0] pt_valid;

   logic [7:0]  s_mem  [3][256];
   logic [7:0]  ct_mem [3][1024];
   logic [17:0] exp_q  [3][$];
   int          wr_cnt [3];
   int          s_wr_cnt [3];
   int          last_addr [3];
   logic [7:0]  ks_init [256];
   logic [7:0]  ks_q [$];
   logic [7:0]  ct_msg [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
   string       msg = "Plaintext";
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      rc4_prga_gen_if #(.MSG_AW(AW)) bus ();

      rc4_prga_gen #(
         .MSG_AW    (AW),
         .LEN_BYTES (g == 1 ? 2 : 1),
         .DROP_N    (g == 2 ? 256 : 0)
      ) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en[g]),
         .rdy      (rdy[g]),
         .mem      (bus),
         .pt_valid (pt_valid[g])
      );

      always @(posedge clk) begin
         bus.s_rddata <= s_mem[g][bus.s_addr];
         if (bus.s_wren) s_mem[g][bus.s_addr] <= bus.s_wrdata;
         bus.ct_rddata <= ct_mem[g][bus.ct_addr];
      end

      always @(negedge clk) begin : mon
         logic [17:0] e;
         if (bus.s_wren) s_wr_cnt[g]++;
         if (bus.pt_wren) begin
            wr_cnt[g]++;
            last_addr[g] = int'(bus.pt_addr);
            if (exp_q[g].size() == 0) begin
               check($sformatf("pt_extra%0d", g), {22'd0, bus.pt_addr}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q[g].pop_front();
               check($sformatf("pt_addr%0d", g), {22'd0, bus.pt_addr}, {22'd0, e[17:8]});
               check($sformatf("pt_data%0d", g), {24'd0, bus.pt_wrdata}, {24'd0, e[7:0]});
            end
         end
      end
   end

   task automatic build_ksa();
      logic [7:0] key [3];
      logic [7:0] t;
      int j;
      key = '{8'h4B, 8'h65, 8'h79};
      for (int i = 0; i < 256; i++) ks_init[i] = 8'(i);
      j = 0;
      for (int i = 0; i < 256; i++) begin
         j = (j + int'(ks_init[i]) + int'(key[i % 3])) % 256;
         t = ks_init[i]; ks_init[i] = ks_init[j]; ks_init[j] = t;
      end
   endtask

   task automatic ref_ks(input int drop, input int n);
      logic [7:0] s [256];
      logic [7:0] t;
      int i, j;
      for (int x = 0; x < 256; x++) s[x] = ks_init[x];
      i = 0; j = 0;
      ks_q.delete();
      for (int x = 0; x < drop + n; x++) begin
         i = (i + 1) % 256;
         j = (j + int'(s[i])) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         t = s[(int'(s[i]) + int'(s[j])) % 256];
         if (x >= drop) ks_q.push_back(t);
      end
   endtask

   task automatic load_s(input int g);
      for (int x = 0; x < 256; x++) s_mem[g][x] = ks_init[x];
   endtask

   task automatic push(input int g, input int addr, input logic [7:0] data);
      exp_q[g].push_back({10'(addr), data});
   endtask

   task automatic push_msg0();
      ct_mem[0][0] = 8'd9;
      for (int n = 0; n < 9; n++) ct_mem[0][1 + n] = ct_msg[n];
      push(0, 0, 8'd9);
      for (int n = 0; n < 9; n++) push(0, 1 + n, msg[n]);
   endtask

   // lat = clock edges from the start edge until rdy is seen high again
   task automatic run(input int g, input bit hold, input int budget, output int lat);
      @(negedge clk);
      en[g] = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1 && !hold) en[g] = 1'b0;
      end while (!rdy[g] && lat < budget);
      en[g] = 1'b0;
      check($sformatf("run_done%0d", g), {31'd0, rdy[g]}, 1);
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat, w, sw, t;
      build_ksa();
      for (int g = 0; g < 3; g++) load_s(g);
      repeat (3) @(negedge clk);

      check("rst_rdy", {29'd0, rdy}, 32'h7);
      check("rst_valid", {29'd0, pt_valid}, 32'h7);
      check("rst_pt_wren", {31'd0, g_dut[0].bus.pt_wren}, 0);
      check("rst_s_addr", {24'd0, g_dut[0].bus.s_addr}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      push_msg0();
      run(0, 1'b0, 200, lat);
      check("msg_lat", lat, 85);
      check("msg_sb_empty", exp_q[0].size(), 0);
      check("msg_valid", {31'd0, pt_valid[0]}, 1);

      w = wr_cnt[0]; sw = s_wr_cnt[0];
      ct_mem[0][0] = 8'd0;
      push(0, 0, 8'd0);
      run(0, 1'b0, 50, lat);
      check("zl_lat_le4", {31'd0, lat <= 4}, 1);
      check("zl_pt_writes", wr_cnt[0] - w, 1);
      check("zl_s_writes", s_wr_cnt[0] - sw, 0);

      load_s(0);
      ref_ks(0, 3);
      ct_mem[0][0] = 8'd3;
      ct_mem[0][1] = ks_q[0] ^ 8'h41;
      ct_mem[0][2] = ks_q[1] ^ 8'h07;
      ct_mem[0][3] = ks_q[2] ^ 8'h42;
      push(0, 0, 8'd3); push(0, 1, 8'h41); push(0, 2, 8'h07);
      w = wr_cnt[0];
`ifdef PRGA_VALID_CHECK_EN
      run(0, 1'b0, 100, lat);
      check("inv_lat", lat, 22);
      check("inv_writes", wr_cnt[0] - w, 3);
      check("inv_valid", {31'd0, pt_valid[0]}, 0);
`else
      push(0, 3, 8'h42);
      run(0, 1'b0, 100, lat);
      check("inv_lat", lat, 31);
      check("inv_writes", wr_cnt[0] - w, 4);
      check("inv_valid", {31'd0, pt_valid[0]}, 1);
`endif
      check("inv_sb_empty", exp_q[0].size(), 0);

      load_s(0);
      push_msg0();
      w = wr_cnt[0];
      run(0, 1'b1, 200, lat);
      check("hold_lat", lat, 85);
      repeat (20) @(negedge clk);
      check("hold_idle", {31'd0, rdy[0]}, 1);
      check("hold_writes", wr_cnt[0] - w, 10);
      check("hold_valid", {31'd0, pt_valid[0]}, 1);
      load_s(0);
      push_msg0();
      run(0, 1'b0, 200, lat);
      check("rerun_lat", lat, 85);
      check("rerun_sb_empty", exp_q[0].size(), 0);

      load_s(1);
      ref_ks(0, 1021);
      ct_mem[1][0] = 8'hFF;
      ct_mem[1][1] = 8'h03;
      push(1, 0, 8'hFD); push(1, 1, 8'h03);
      for (int n = 0; n < 1021; n++) begin
         ct_mem[1][2 + n] = 8'($urandom);
         push(1, 2 + n, ks_q[n] ^ ct_mem[1][2 + n]);
      end
      w = wr_cnt[1];
      run(1, 1'b0, 12000, lat);
      check("sat_last_addr", last_addr[1], 1022);
      check("sat_writes", wr_cnt[1] - w, 1023);
      check("sat_sb_empty", exp_q[1].size(), 0);

      load_s(2);
      ref_ks(256, 16);
      ct_mem[2][0] = 8'd16;
      push(2, 0, 8'd16);
      for (int n = 0; n < 16; n++) begin
         ct_mem[2][1 + n] = 8'($urandom);
         push(2, 1 + n, ks_q[n] ^ ct_mem[2][1 + n]);
      end
      run(2, 1'b0, 5000, lat);
      check("drop_sb_empty", exp_q[2].size(), 0);

      load_s(2);
      push(2, 0, 8'd16);
      for (int n = 0; n < 4; n++) push(2, 1 + n, ks_q[n] ^ ct_mem[2][1 + n]);
      w = wr_cnt[2];
      @(negedge clk); en[2] = 1'b1;
      @(negedge clk); en[2] = 1'b0;
      t = 0;
      while ((wr_cnt[2] - w) < 5 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("mid_reach_byte5", {31'd0, t < 5000}, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rdy", {31'd0, rdy[2]}, 1);
      check("mid_rst_s_wren", {31'd0, g_dut[2].bus.s_wren}, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("mid_rst_writes", wr_cnt[2] - w, 5);
      check("mid_rst_sb_empty", exp_q[2].size(), 0);
      check("mid_rst_idle", {31'd0, rdy[2]}, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
